// File: rtl/aes_tx_ser.sv
// Block serializer: pops one block from a FWFT FIFO and emits it lane by lane; first lane 1 cycle after the pop edge.
// No backpressure from the sink; en=0 stalls every register and suppresses require.
module aes_tx_ser #(
  parameter int BLOCK_W   = 128,
  parameter int LANE_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int N_LANES  = BLOCK_W / LANE_W,
  localparam int CNT_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [BLOCK_W-1:0] data,
  input  logic [CNT_W-1:0]   len,
  input  logic               empty,
  output logic               require,
  output logic               shakehand,
  output logic [LANE_W-1:0]  tx,
  output logic               tx_valid,
  output logic               tx_last,
  output logic               busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [LANE_W-1:0]  tx_q, tx_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic               sh_q, sh_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;

  logic [LANE_W-1:0]  blk_lane [N_LANES];
  logic [LANE_W-1:0]  head_lane0;
  logic [CNT_W-1:0]   len_c;
  logic [CNT_W-1:0]   nxt_idx;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    if (MSB_FIRST) begin : g_msb
      assign blk_lane[i] = blk_q[BLOCK_W-1-i*LANE_W -: LANE_W];
    end else begin : g_lsb
      assign blk_lane[i] = blk_q[i*LANE_W +: LANE_W];
    end
  end

  if (MSB_FIRST) begin : g_head_msb
    assign head_lane0 = data[BLOCK_W-1 -: LANE_W];
  end else begin : g_head_lsb
    assign head_lane0 = data[LANE_W-1:0];
  end

  // A len field can only overrun the block when N_LANES is not a power of two.
  if ((2 ** CNT_W) == N_LANES) begin : g_len_pow2
    assign len_c = len;
  end else begin : g_len_clamp
    assign len_c = (len > CNT_W'(N_LANES - 1)) ? CNT_W'(N_LANES - 1) : len;
  end

  assign nxt_idx = idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    blk_d   = blk_q;
    tx_d    = tx_q;
    vld_d   = vld_q;
    last_d  = last_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    req_d   = 1'b0;
    if (en) begin
      if (state_q == SEND && idx_q != len_q) begin
        idx_d  = nxt_idx;
        tx_d   = blk_lane[nxt_idx];
        sh_d   = ~sh_q;
        last_d = (nxt_idx == len_q);
      end else if (!empty) begin
        // Covers both a fresh start from IDLE and a zero-bubble reload after the last lane.
        state_d = SEND;
        blk_d   = data;
        len_d   = len_c;
        idx_d   = '0;
        tx_d    = head_lane0;
        vld_d   = 1'b1;
        sh_d    = ~sh_q;
        last_d  = (len_c == '0);
        busy_d  = 1'b1;
        req_d   = 1'b1;
      end else begin
        state_d = IDLE;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      blk_q   <= '0;
      tx_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      sh_q    <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      blk_q   <= blk_d;
      tx_q    <= tx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign require   = req_q;
  assign shakehand = sh_q;
  assign tx        = tx_q;
  assign tx_valid  = vld_q;
  assign tx_last   = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_tx_ser.sv
// Scoreboard bench for aes_tx_ser: an 8-bit MSB-first instance and a 32-bit LSB-first instance.
module tb_aes_tx_ser;

  typedef struct { logic [127:0] d; int l; } blk_t;
  typedef struct { logic [127:0] v; logic last; } exp_t;

  localparam logic [127:0] PAT = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         en1, en2, empty1, empty2;
  logic [127:0] data1, data2;
  logic [3:0]   len1;
  logic [1:0]   len2;
  logic         require1, shakehand1, tx_valid1, tx_last1, busy1;
  logic         require2, shakehand2, tx_valid2, tx_last2, busy2;
  logic [7:0]   tx1;
  logic [31:0]  tx2;

  aes_tx_ser u_dut8 (
    .clk(clk), .rst(rst), .en(en1), .data(data1), .len(len1), .empty(empty1),
    .require(require1), .shakehand(shakehand1), .tx(tx1), .tx_valid(tx_valid1),
    .tx_last(tx_last1), .busy(busy1));

  aes_tx_ser #(.BLOCK_W(128), .LANE_W(32), .MSB_FIRST(1'b0)) u_dut32 (
    .clk(clk), .rst(rst), .en(en2), .data(data2), .len(len2), .empty(empty2),
    .require(require2), .shakehand(shakehand2), .tx(tx2), .tx_valid(tx_valid2),
    .tx_last(tx_last2), .busy(busy2));

  always #5 clk = ~clk;

  blk_t fifo1[$], fifo2[$];
  exp_t sb1[$], sb2[$];
  int   req_cyc1[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc_n = 0;
  int   nreq1 = 0, nreq2 = 0, lanes1 = 0, lanes2 = 0;
  int   first1 = -1, last1 = -1;
  logic psh1 = 1'b0, psh2 = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lane_of(input logic [127:0] d, input int lw, input bit msb, input int i);
    logic [127:0] mask;
    mask = (128'd1 << lw) - 128'd1;
    if (msb) return (d >> (128 - (i + 1) * lw)) & mask;
    return (d >> (i * lw)) & mask;
  endfunction

  task automatic drive();
    empty1 = (fifo1.size() == 0);
    data1  = empty1 ? '0 : fifo1[0].d;
    len1   = empty1 ? '0 : 4'(fifo1[0].l);
    empty2 = (fifo2.size() == 0);
    data2  = empty2 ? '0 : fifo2[0].d;
    len2   = empty2 ? '0 : 2'(fifo2[0].l);
  endtask

  task automatic push1(input logic [127:0] d, input int l);
    exp_t e;
    fifo1.push_back('{d: d, l: l});
    for (int i = 0; i <= l; i++) begin
      e.v = lane_of(d, 8, 1'b1, i);
      e.last = (i == l);
      sb1.push_back(e);
    end
    drive();
  endtask

  task automatic push2(input logic [127:0] d, input int l);
    exp_t e;
    fifo2.push_back('{d: d, l: l});
    for (int i = 0; i <= l; i++) begin
      e.v = lane_of(d, 32, 1'b0, i);
      e.last = (i == l);
      sb2.push_back(e);
    end
    drive();
  endtask

  // One clock: FIFO pops right after the edge that raised require, lanes compared at the falling edge.
  task automatic cyc();
    exp_t e;
    @(posedge clk); #1;
    cyc_n++;
    if (require1) begin
      nreq1++;
      req_cyc1.push_back(cyc_n);
      chk("req1_fifo_nonempty", 128'(fifo1.size() != 0), 128'd1);
      if (fifo1.size() != 0) fifo1.delete(0);
    end
    if (require2) begin
      nreq2++;
      chk("req2_fifo_nonempty", 128'(fifo2.size() != 0), 128'd1);
      if (fifo2.size() != 0) fifo2.delete(0);
    end
    drive();
    @(negedge clk); #1;
    if (!rst && shakehand1 != psh1) begin
      psh1 = shakehand1;
      lanes1++;
      if (first1 < 0) first1 = cyc_n;
      last1 = cyc_n;
      chk("vld1", 128'(tx_valid1), 128'd1);
      if (sb1.size() == 0) chk("lane1_extra", 128'(sb1.size()), 128'd1);
      else begin
        e = sb1.pop_front();
        chk("tx1", 128'(tx1), e.v);
        chk("last1", 128'(tx_last1), 128'(e.last));
      end
    end
    if (!rst && shakehand2 != psh2) begin
      psh2 = shakehand2;
      lanes2++;
      chk("vld2", 128'(tx_valid2), 128'd1);
      if (sb2.size() == 0) chk("lane2_extra", 128'(sb2.size()), 128'd1);
      else begin
        e = sb2.pop_front();
        chk("tx2", 128'(tx2), e.v);
        chk("last2", 128'(tx_last2), 128'(e.last));
      end
    end
  endtask

  task automatic drain(input int budget);
    int  n;
    logic pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      cyc();
      n++;
      pend = (fifo1.size() != 0) || (sb1.size() != 0) || tx_valid1 ||
             (fifo2.size() != 0) || (sb2.size() != 0) || tx_valid2;
    end
    chk("drain_done", 128'(pend), 128'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req1"}, 128'(require1), 128'd0);
    chk({tag, "_sh1"}, 128'(shakehand1), 128'd0);
    chk({tag, "_tx1"}, 128'(tx1), 128'd0);
    chk({tag, "_vld1"}, 128'(tx_valid1), 128'd0);
    chk({tag, "_last1"}, 128'(tx_last1), 128'd0);
    chk({tag, "_busy1"}, 128'(busy1), 128'd0);
    chk({tag, "_req2"}, 128'(require2), 128'd0);
    chk({tag, "_sh2"}, 128'(shakehand2), 128'd0);
    chk({tag, "_tx2"}, 128'(tx2), 128'd0);
    chk({tag, "_vld2"}, 128'(tx_valid2), 128'd0);
    chk({tag, "_busy2"}, 128'(busy2), 128'd0);
  endtask

  initial begin
    int base, n, r0;
    logic sh;
    rst = 1'b1;
    en1 = 1'b1;
    en2 = 1'b1;
    drive();
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single full block
    base = lanes1; r0 = nreq1; first1 = -1;
    push1(PAT, 15);
    drain(60);
    chk("t2_lanes", 128'(lanes1 - base), 128'd16);
    chk("t2_reqs", 128'(nreq1 - r0), 128'd1);
    chk("t2_contig", 128'(last1 - first1), 128'd15);
    chk("t2_vld_after", 128'(tx_valid1), 128'd0);
    chk("t2_busy_after", 128'(busy1), 128'd0);

    // Back-to-back blocks
    base = lanes1; first1 = -1; req_cyc1.delete();
    push1(PAT, 15);
    push1(~PAT, 15);
    drain(80);
    chk("t3_lanes", 128'(lanes1 - base), 128'd32);
    chk("t3_contig", 128'(last1 - first1), 128'd31);
    chk("t3_nreq", 128'(req_cyc1.size()), 128'd2);
    if (req_cyc1.size() == 2) chk("t3_req_gap", 128'(req_cyc1[1] - req_cyc1[0]), 128'd16);

    // Stall after the 5th lane
    base = lanes1;
    push1(PAT, 15);
    n = 0;
    while (lanes1 - base < 5 && n < 40) begin cyc(); n++; end
    chk("t4_reach5", 128'(lanes1 - base), 128'd5);
    en1 = 1'b0;
    sh = shakehand1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_tx_hold", 128'(tx1), 128'h44);
      chk("t4_sh_hold", 128'(shakehand1), 128'(sh));
      chk("t4_req_low", 128'(require1), 128'd0);
    end
    en1 = 1'b1;
    drain(60);
    chk("t4_lanes", 128'(lanes1 - base), 128'd16);

    // Partial block followed by a queued full block
    base = lanes1; first1 = -1;
    push1(PAT, 3);
    push1(PAT, 15);
    drain(80);
    chk("t5_lanes", 128'(lanes1 - base), 128'd20);
    chk("t5_contig", 128'(last1 - first1), 128'd19);

    // 32-bit LSB-first lanes, then reset mid-block
    base = lanes2;
    push2(PAT, 3);
    drain(40);
    chk("t6_lanes", 128'(lanes2 - base), 128'd4);
    base = lanes2; r0 = nreq2;
    push2(PAT, 3);
    n = 0;
    while (lanes2 - base < 2 && n < 40) begin cyc(); n++; end
    chk("t6_reach2", 128'(lanes2 - base), 128'd2);
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    sb2.delete();
    psh1 = 1'b0;
    psh2 = 1'b0;
    cyc();
    rst = 1'b0;
    base = lanes2;
    for (int i = 0; i < 10; i++) cyc();
    chk("t6_no_resend", 128'(lanes2 - base), 128'd0);
    chk("t6_one_req", 128'(nreq2 - r0), 128'd1);
    chk("t6_vld_idle", 128'(tx_valid2), 128'd0);
    chk("t6_busy_idle", 128'(busy2), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_tx_ser.md
Name: aes_tx_ser

Overview:
Parametrised output serializer for the AES verify platform. It pops whole cipher blocks from an upstream first-word-fall-through FIFO and emits them as a stream of LANE_W-bit lanes on the output port. Each lane carries a toggling shakehand strobe. The block adds a per-block lane count for partial blocks, selectable lane order, zero-bubble back-to-back blocks, explicit valid/last/busy flags and an enable-based stall.

Parameters:
BLOCK_W, 128, width of one input block in bits.
LANE_W, 8, width of one output lane; BLOCK_W must be an integer multiple of LANE_W.
MSB_FIRST, 1, 1 = lane 0 is data[BLOCK_W-1 -: LANE_W]; 0 = lane 0 is data[LANE_W-1:0].
(derived) N_LANES = BLOCK_W/LANE_W; CNT_W = max(1, clog2(N_LANES)).

Ports:
clk        in   1        system clock; all state updates on the rising edge.
rst        in   1        reset; asynchronous, active-high.
en         in   1        clock-enable; 0 = stall, all state held.
data       in   BLOCK_W  FIFO head block; valid whenever empty=0.
len        in   CNT_W    lanes to send minus 1 for the head block; sampled together with data.
empty      in   1        FIFO empty flag.
require    out  1        one-cycle pop strobe to the FIFO.
shakehand  out  1        toggles once per new lane presented on tx.
tx         out  LANE_W   current lane (registered).
tx_valid   out  1        tx holds a valid lane.
tx_last    out  1        the current lane is the final lane of its block.
busy       out  1        1 while in SEND.

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, stored block=0, stored len=0. Outputs: require=0, shakehand=0, tx=0, tx_valid=0, tx_last=0, busy=0. Reset takes effect immediately, including mid-block; any partially sent block is discarded and is not re-popped.
- All outputs are registered. When en=0, state, idx, tx, tx_valid, tx_last, shakehand and busy hold, and require is driven 0 on that edge.
- IDLE: on an en edge with empty=0:
  - latch data and len;
  - require=1 for exactly that cycle;
  - tx=lane 0, tx_valid=1, shakehand toggles, tx_last=(len==0);
  - idx=0, go to SEND.
  - With empty=1 the block stays in IDLE: tx_valid=0, tx holds its last value.
- SEND, idx<stored len: each en edge sets idx+1, tx=lane idx+1, toggles shakehand, require=0, and sets tx_last=(idx+1==stored len).
- SEND, idx==stored len (last lane showing), on an en edge:
  - empty=0: load the next block as in IDLE, in the same cycle. There is no bubble and the block stays in SEND.
  - empty=1: go to IDLE with tx_valid=0, tx_last=0, busy=0, and shakehand unchanged.
- Latency: first lane appears 1 cycle after the sampling edge. A block of len+1 lanes occupies exactly len+1 enabled cycles. Sustained throughput is 1 lane per enabled cycle.
- len > N_LANES-1 (possible only when N_LANES is not a power of 2) is clamped to N_LANES-1.
- require is never asserted while empty=0 is not observed on the same edge. At most one require is issued per block.
- idx wraps only via reload; it never exceeds N_LANES-1.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> require=0, shakehand=0, tx=0, tx_valid=0, tx_last=0, busy=0 immediately, before the next clk edge.
2. Single full block, defaults: data=0x00112233445566778899AABBCCDDEEFF, len=15, en=1, empty then 1 -> exactly one require pulse. tx=0x00,0x11,...,0xFF on 16 consecutive cycles, shakehand toggling each cycle, tx_last only on 0xFF. Then tx_valid=0 and busy=0.
3. Back-to-back: two full blocks queued -> two require pulses exactly 16 cycles apart, 32 contiguous valid lanes, no tx_valid gap.
4. Stall: en=0 for 3 cycles after the 5th lane -> tx=0x44 and shakehand are held, require=0. On resume, continues 0x55..0xFF with 16 lanes total.
5. Partial block: len=3 -> 4 lanes 0x00,0x11,0x22,0x33 with tx_last on 0x33. The next queued block starts on the following cycle.
6. LANE_W=32, MSB_FIRST=0, len=3, same data -> tx=0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233. Then rst asserted after lane 2 -> IDLE, and the block is not resent.
